// File: rtl/seq_mac.sv
// seq_mac: sequential 5x5 shift-add multiplier with optional accumulate.
// A start event (rising edge of io_in[11]) latches the operands and runs five
// shift-add steps; the 10-bit result is published when the operation ends and
// held until the next start event.
module seq_mac (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] io_in,
    output logic [11:0] io_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        start_q_r;
    logic        mode_r;
    logic        mode_s;
    logic [4:0]  a_r;
    logic [4:0]  a_s;
    logic [4:0]  b_r;
    logic [4:0]  b_s;
    logic [2:0]  step_r;
    logic [2:0]  step_s;
    logic [9:0]  partial_r;
    logic [9:0]  partial_s;
    logic [9:0]  result_r;
    logic [9:0]  result_s;
    logic        busy_r;
    logic        busy_s;
    logic        done_r;
    logic        done_s;

    logic        start_s;
    logic        start_ev_s;
    logic [9:0]  addend_s;
    logic [9:0]  sum_s;

    assign start_s    = io_in[11];
    // Only a low-to-high transition of start launches work; a held level does not.
    assign start_ev_s = start_s & ~start_q_r;

    // Shifted multiplicand for the current step, gated by the matching B bit.
    always_comb begin
        addend_s = 10'd0;
        if (b_r[step_r]) begin
            addend_s = {5'd0, a_r} << step_r;
        end else begin
            addend_s = 10'd0;
        end
    end

    // Partial sum wraps modulo 1024 by construction of the 10-bit adder.
    assign sum_s = partial_r + addend_s;

    // Next-state and datapath update for the IDLE/RUN/DONE controller.
    always_comb begin
        state_s   = state_r;
        mode_s    = mode_r;
        a_s       = a_r;
        b_s       = b_r;
        step_s    = step_r;
        partial_s = partial_r;
        result_s  = result_r;
        case (state_r)
            IDLE, DONE: begin
                if (start_ev_s) begin
                    mode_s    = io_in[10];
                    a_s       = io_in[9:5];
                    b_s       = io_in[4:0];
                    partial_s = io_in[10] ? result_r : 10'd0;
                    step_s    = 3'd0;
                    state_s   = RUN;
                end else begin
                    state_s   = state_r;
                end
            end
            RUN: begin
                // Operands are frozen here; a new start edge is deliberately ignored.
                partial_s = sum_s;
                step_s    = step_r + 3'd1;
                if (step_r == 3'd4) begin
                    result_s = sum_s;
                    state_s  = DONE;
                end else begin
                    state_s  = RUN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s == RUN);
        done_s = (state_s == DONE);
    end

    // State, operand, datapath and status registers; reset wins over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            start_q_r <= 1'b0;
            mode_r    <= 1'b0;
            a_r       <= 5'd0;
            b_r       <= 5'd0;
            step_r    <= 3'd0;
            partial_r <= 10'd0;
            result_r  <= 10'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            start_q_r <= start_s;
            mode_r    <= mode_s;
            a_r       <= a_s;
            b_r       <= b_s;
            step_r    <= step_s;
            partial_r <= partial_s;
            result_r  <= result_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    // Outputs come straight from flops so io_in never reaches io_out combinationally.
    assign io_out = {busy_r, done_r, result_r};

endmodule

// File: tb/tb_seq_mac.sv
// Self-checking bench for seq_mac: a sequential table of operations plus
// hand-written sequences for retrigger, reset-abort, mid-run start and
// start-during-reset behaviour. Expected results go through a queue.
module tb_seq_mac;

    logic        clock;
    logic        reset;
    logic [11:0] io_in;
    logic [11:0] io_out;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [9:0] exp_q[$];
    logic [9:0] prev_res;

    typedef struct {
        logic       mode;
        logic [4:0] a;
        logic [4:0] b;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[9];

    seq_mac dut (
        .clock  (clock),
        .reset  (reset),
        .io_in  (io_in),
        .io_out (io_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Start pulse (or held level) with operands; lower bits are scrambled afterwards.
    task automatic launch(input logic m, input logic [4:0] a, input logic [4:0] b, input logic hold);
        io_in = {1'b1, m, a, b};
        tick();
        check("launch_status", {10'd0, io_out[11:10]}, 12'h002);
        if (!hold) io_in = {1'b0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023))};
    endtask

    // Count busy samples until done (bounded), checking held result, then score.
    task automatic wait_done(input string name, input int exp_busy);
        int busy_cnt = 0;
        int cycles = 0;
        logic [9:0] e;
        while (!io_out[10] && cycles < 20) begin
            if (io_out[11]) begin
                busy_cnt++;
                check({name, "_held"}, {2'd0, io_out[9:0]}, {2'd0, prev_res});
            end
            tick();
            cycles++;
        end
        if (cycles >= 20) begin
            total_cnt++;
            $display("FAIL %s_timeout: done not seen within 20 cycles", name);
        end
        check({name, "_busy_cycles"}, 12'(busy_cnt), 12'(exp_busy));
        check({name, "_done_only"}, {10'd0, io_out[11:10]}, 12'h001);
        if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL %s_queue: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check({name, "_result"}, {2'd0, io_out[9:0]}, {2'd0, e});
            prev_res = e;
        end
    endtask

    initial begin
        bit saw_busy;
        bit res_moved;
        vecs[0] = '{1'b0, 5'd3,  5'd5,  10'd15};
        vecs[1] = '{1'b0, 5'd31, 5'd31, 10'd961};
        vecs[2] = '{1'b1, 5'd31, 5'd31, 10'd898};
        vecs[3] = '{1'b1, 5'd31, 5'd31, 10'd835};
        vecs[4] = '{1'b0, 5'd0,  5'd17, 10'd0};
        vecs[5] = '{1'b1, 5'd1,  5'd1,  10'd1};
        vecs[6] = '{1'b0, 5'd16, 5'd16, 10'd256};
        vecs[7] = '{1'b1, 5'd31, 5'd1,  10'd287};
        vecs[8] = '{1'b0, 5'd31, 5'd0,  10'd0};

        reset = 1'b1;
        io_in = 12'h000;
        prev_res = 10'd0;
        tick();
        tick();
        check("reset_state", io_out, 12'h000);
        reset = 1'b0;
        tick();
        check("idle_after_reset", io_out, 12'h000);

        // Table: each operation chains from the previous result.
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(vecs[i].exp);
            launch(vecs[i].mode, vecs[i].a, vecs[i].b, 1'b0);
            wait_done($sformatf("vec%0d", i), 5);
            if (i == 0) check("vec0_io_out", io_out, 12'h40F);
        end

        // Held start must not retrigger, even with new operands on the pins.
        exp_q.push_back(10'd30);
        launch(1'b0, 5'd10, 5'd3, 1'b1);
        wait_done("hold_op", 5);
        io_in = {1'b1, 1'b1, 5'd31, 5'd31};
        saw_busy = 1'b0;
        res_moved = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (io_out[11]) saw_busy = 1'b1;
            if (io_out[9:0] != 10'd30) res_moved = 1'b1;
        end
        check("hold_no_busy", {11'd0, saw_busy}, 12'h000);
        check("hold_result_stable", {11'd0, res_moved}, 12'h000);
        check("hold_io_out", io_out, 12'h41E);
        io_in = {1'b0, 1'b1, 5'd31, 5'd31};
        tick();
        exp_q.push_back(10'd991);
        launch(1'b1, 5'd31, 5'd31, 1'b0);
        wait_done("rearm_op", 5);

        // Reset on the third busy cycle aborts the operation and clears the result.
        launch(1'b0, 5'd7, 5'd9, 1'b0);
        tick();
        tick();
        check("abort_still_busy", {10'd0, io_out[11:10]}, 12'h002);
        reset = 1'b1;
        tick();
        check("abort_reset_out", io_out, 12'h000);
        reset = 1'b0;
        prev_res = 10'd0;
        tick();
        exp_q.push_back(10'd6);
        launch(1'b1, 5'd2, 5'd3, 1'b0);
        wait_done("after_abort", 5);

        // A start edge mid-run is ignored; the latched operands complete.
        exp_q.push_back(10'd30);
        launch(1'b0, 5'd5, 5'd6, 1'b0);
        tick();
        io_in = {1'b1, 1'b0, 5'd31, 5'd31};
        tick();
        io_in = {1'b0, 1'b0, 5'd31, 5'd31};
        wait_done("midrun_start", 3);

        // Start already high while reset releases counts as a start event.
        reset = 1'b1;
        io_in = {1'b1, 1'b0, 5'd3, 5'd5};
        tick();
        check("reset_with_start", io_out, 12'h000);
        reset = 1'b0;
        prev_res = 10'd0;
        exp_q.push_back(10'd15);
        tick();
        check("first_edge_start", {10'd0, io_out[11:10]}, 12'h002);
        wait_done("first_edge_op", 5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/seq_mac.md
SEQ_MAC -- requirements
Module: seq_mac

Interface
REQ-001: clock  input  1  sole clock; all state updates on its rising edge.
REQ-002: reset  input  1  synchronous, active-high reset.
REQ-003: io_in  input  12  [11]=start, [10]=mode (0 multiply, 1 multiply-accumulate), [9:5]=A (unsigned), [4:0]=B (unsigned).
REQ-004: io_out  output  12  [11]=busy, [10]=done, [9:0]=result (unsigned).
REQ-005: Parameters SHALL be none; widths are fixed by the 12-in/12-out pin frame.

Function
REQ-006: State machine SHALL have three states: IDLE, RUN, DONE.
REQ-007: The block SHALL register start every cycle (start_q) and SHALL detect a start event as start=1 and start_q=0.
REQ-008: In IDLE or DONE, a start event at an edge SHALL latch A, B and mode, load partial = (mode ? result : 0), clear step counter to 0, and enter RUN.
REQ-009: In RUN, each edge SHALL add (A << step) to partial when B[step]=1, then increment step.
REQ-010: Partial SHALL be 10 bits; additions SHALL wrap modulo 1024 (no saturation, no overflow flag).
REQ-011: On the edge performing step 4 (5th RUN edge), result SHALL load the final partial and state SHALL go to DONE.
REQ-012: Latency: a start event captured at edge k SHALL give busy=1 after edges k..k+4 and done=1 with the new result after edge k+5.
REQ-013: busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE; never both.
REQ-014: result SHALL hold its previous value throughout RUN and change only at the RUN->DONE edge.
REQ-015: DONE SHALL persist (result held) until the next start event; no automatic return to IDLE.
REQ-016: A start event during RUN SHALL be ignored; operands latched at entry SHALL be used to completion.
REQ-017: start held high SHALL NOT retrigger; a new operation requires start to go low then high.
REQ-018: A start event in DONE SHALL launch a new operation on that edge (done falls, busy rises after the same edge).
REQ-019: io_in[9:0] SHALL be ignored except on the edge that captures a start event.
REQ-020: io_out SHALL be driven directly from registers (no combinational path from io_in).

Reset
REQ-021: With reset=1 at an edge, state SHALL become IDLE, result=0, partial=0, step=0, start_q=0, latched operands=0.
REQ-022: After that edge io_out SHALL read 12'h000.
REQ-023: Reset SHALL take priority over all other activity, including mid-RUN; the aborted operation SHALL leave no effect.
REQ-024: If start=1 on the first edge with reset=0, that edge SHALL count as a start event (start_q reset to 0).

Verification
REQ-025: Reset; mode=0, A=3, B=5, one-cycle start pulse -> busy=1 for 5 cycles, then done=1, result=15, io_out=12'h40F.
REQ-026: Following REQ-025, mode=0, A=31, B=31, start pulse -> result=961 after 6 edges; busy never coincides with done.
REQ-027: Following REQ-026, mode=1, A=31, B=31, start pulse -> result=(961+961) mod 1024=898; result reads 961 during all 5 busy cycles.
REQ-028: After done, hold start=1 for 20 cycles with new operands -> no retrigger; done=1, result unchanged; lower start, raise again -> new operation begins.
REQ-029: Start an operation (A=7, B=9), assert reset on 3rd busy cycle -> io_out=0 next edge; then mode=1, A=2, B=3 start -> result=6 (accumulator cleared).
REQ-030: Start A=5, B=6 mode=0; on 2nd busy cycle drop and re-raise start with A=31, B=31 -> ignored; result=30 at done.
